// File: rtl/net_cmd_buffer.sv
// net_cmd_buffer: filters mesh packets by core ID and queues
// INSTR/REG/PC/BAR commands in a FIFO popped by valid/yumi.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   pkt_valid_i          packet present (no backpressure)
//   pkt_id_i             destination ID
//   pkt_op_i             op: 0 NULL, 1 INSTR, 2 REG, 3 PC, 4 BAR
//   pkt_addr_i           packet address
//   pkt_data_i           packet data
//   cmd_valid_o          FIFO head valid
//   cmd_op_o             head op (0 when empty)
//   cmd_addr_o           head address
//   cmd_data_o           head data
//   cmd_yumi_i           consumer takes the head this cycle
//   count_o              occupancy
//   overflow_o           sticky: packet dropped on full FIFO
//   illegal_op_o         sticky: matched packet with op 5..7
//   drop_cnt_o           saturating drop count
module net_cmd_buffer #(
   parameter int unsigned depth_p      = 4,
   parameter int unsigned id_width_p   = 10,
   parameter int unsigned addr_width_p = 10,
   parameter int unsigned data_width_p = 32,
   parameter logic [id_width_p-1:0] net_id_p = id_width_p'(1),
   parameter bit bcast_en_p = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pkt_valid_i,
   input  logic [id_width_p-1:0]      pkt_id_i,
   input  logic [2:0]                 pkt_op_i,
   input  logic [addr_width_p-1:0]    pkt_addr_i,
   input  logic [data_width_p-1:0]    pkt_data_i,
   output logic                       cmd_valid_o,
   output logic [2:0]                 cmd_op_o,
   output logic [addr_width_p-1:0]    cmd_addr_o,
   output logic [data_width_p-1:0]    cmd_data_o,
   input  logic                       cmd_yumi_i,
   output logic [$clog2(depth_p):0]   count_o,
   output logic                       overflow_o,
   output logic                       illegal_op_o,
   output logic [7:0]                 drop_cnt_o
);

   localparam int unsigned ptr_w = $clog2(depth_p);
   localparam int unsigned cnt_w = ptr_w + 1;
   localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth_p);

   typedef struct packed {
      logic [2:0]              op;
      logic [addr_width_p-1:0] addr;
      logic [data_width_p-1:0] data;
   } cmd_t;

   cmd_t mem [depth_p];

   logic [ptr_w-1:0] rd_ptr;
   logic [ptr_w-1:0] wr_ptr;
   logic [cnt_w-1:0] count;
   logic             overflow;
   logic             illegal;
   logic [7:0]       drop_cnt;

   logic id_hit;
   logic match;
   logic op_legal;
   logic op_bad;
   logic full;
   logic pop;
   logic push;
   logic drop;
   cmd_t head;

   // Packet classification
   always_comb begin
      id_hit   = (pkt_id_i == net_id_p) ||
                 (bcast_en_p && (&pkt_id_i));
      match    = pkt_valid_i && id_hit;
      op_legal = (pkt_op_i != 3'd0) && (pkt_op_i <= 3'd4);
      op_bad   = (pkt_op_i >= 3'd5);
   end

   // Handshake decisions. A yumi on an empty FIFO is ignored;
   // when full, a same-cycle pop frees the slot for the push.
   always_comb begin
      full = (count == depth_c);
      pop  = cmd_yumi_i && (count != '0);
      push = match && op_legal && (!full || pop);
      drop = match && (op_bad || (op_legal && !push));
   end

   // Storage array; contents need no reset since the
   // valid state is carried by the pointers and count.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr] <= '{op:   pkt_op_i,
                          addr: pkt_addr_i,
                          data: pkt_data_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         unique case (1'b1)
            (push && !pop): count <= count + cnt_w'(1);
            (pop && !push): count <= count - cnt_w'(1);
            default:        count <= count;
         endcase
         if (match && op_legal && !push) begin
            overflow <= 1'b1;
         end
         if (match && op_bad) begin
            illegal <= 1'b1;
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // Head is read straight from storage: no input bypass
   always_comb begin
      head        = mem[rd_ptr];
      cmd_valid_o = (count != '0);
      cmd_op_o    = cmd_valid_o ? head.op : 3'd0;
      cmd_addr_o  = head.addr;
      cmd_data_o  = head.data;
   end

   assign count_o      = count;
   assign overflow_o   = overflow;
   assign illegal_op_o = illegal;
   assign drop_cnt_o   = drop_cnt;

endmodule

// File: tb/tb_net_cmd_buffer.sv
// tb_net_cmd_buffer: directed self-checking bench for
// net_cmd_buffer (depth 4, id 1, broadcast enabled).
module tb_net_cmd_buffer;

   logic        clk;
   logic        reset;
   logic        pkt_valid_i;
   logic [9:0]  pkt_id_i;
   logic [2:0]  pkt_op_i;
   logic [9:0]  pkt_addr_i;
   logic [31:0] pkt_data_i;
   logic        cmd_valid_o;
   logic [2:0]  cmd_op_o;
   logic [9:0]  cmd_addr_o;
   logic [31:0] cmd_data_o;
   logic        cmd_yumi_i;
   logic [2:0]  count_o;
   logic        overflow_o;
   logic        illegal_op_o;
   logic [7:0]  drop_cnt_o;

   int checks;
   int failures;

   net_cmd_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .pkt_valid_i  (pkt_valid_i),
      .pkt_id_i     (pkt_id_i),
      .pkt_op_i     (pkt_op_i),
      .pkt_addr_i   (pkt_addr_i),
      .pkt_data_i   (pkt_data_i),
      .cmd_valid_o  (cmd_valid_o),
      .cmd_op_o     (cmd_op_o),
      .cmd_addr_o   (cmd_addr_o),
      .cmd_data_o   (cmd_data_o),
      .cmd_yumi_i   (cmd_yumi_i),
      .count_o      (count_o),
      .overflow_o   (overflow_o),
      .illegal_op_o (illegal_op_o),
      .drop_cnt_o   (drop_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // One clock with the given inputs, then release them.
   task automatic cyc(input logic v, input logic [9:0] id,
                      input logic [2:0] op,
                      input logic [9:0] addr,
                      input logic [31:0] data,
                      input logic yumi);
      pkt_valid_i = v;
      pkt_id_i    = id;
      pkt_op_i    = op;
      pkt_addr_i  = addr;
      pkt_data_i  = data;
      cmd_yumi_i  = yumi;
      @(posedge clk);
      #1;
      pkt_valid_i = 1'b0;
      cmd_yumi_i  = 1'b0;
   endtask

   task automatic push(input logic [31:0] data);
      cyc(1'b1, 10'd1, 3'd1, 10'd0, data, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, 10'd0, 3'd0, 10'd0, 32'd0, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b0;
      pkt_valid_i = 1'b0;
      pkt_id_i    = '0;
      pkt_op_i    = '0;
      pkt_addr_i  = '0;
      pkt_data_i  = '0;
      cmd_yumi_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count_o), 0);
      check("rst_valid", 32'(cmd_valid_o), 0);
      check("rst_op", 32'(cmd_op_o), 0);
      check("rst_ovf", 32'(overflow_o), 0);
      check("rst_ill", 32'(illegal_op_o), 0);
      check("rst_drop", 32'(drop_cnt_o), 0);
      reset = 1'b1;

      // Basic round trip
      cyc(1'b1, 10'd1, 3'd2, 10'd5, 32'hDEADBEEF, 1'b0);
      check("rt_valid", 32'(cmd_valid_o), 1);
      check("rt_op", 32'(cmd_op_o), 2);
      check("rt_addr", 32'(cmd_addr_o), 5);
      check("rt_data", cmd_data_o, 32'hDEADBEEF);
      check("rt_count", 32'(count_o), 1);
      pop();
      check("rt_pop_count", 32'(count_o), 0);
      check("rt_pop_valid", 32'(cmd_valid_o), 0);
      check("rt_pop_op", 32'(cmd_op_o), 0);

      // Yumi while empty is ignored
      pop();
      check("empty_yumi_count", 32'(count_o), 0);

      // Filtering
      cyc(1'b1, 10'd2, 3'd1, 10'd0, 32'h1, 1'b0);
      check("flt_other_id", 32'(count_o), 0);
      cyc(1'b0, 10'd1, 3'd1, 10'd0, 32'h1, 1'b0);
      check("flt_no_valid", 32'(count_o), 0);
      cyc(1'b1, 10'h3FF, 3'd4, 10'd7, 32'h11, 1'b0);
      check("flt_bcast_cnt", 32'(count_o), 1);
      check("flt_bcast_op", 32'(cmd_op_o), 4);
      check("flt_bcast_data", cmd_data_o, 32'h11);
      pop();
      cyc(1'b1, 10'd1, 3'd0, 10'd0, 32'h2, 1'b0);
      check("flt_null_cnt", 32'(count_o), 0);
      check("flt_null_drop", 32'(drop_cnt_o), 0);
      check("flt_null_ill", 32'(illegal_op_o), 0);
      cyc(1'b1, 10'd1, 3'd6, 10'd0, 32'h3, 1'b0);
      check("flt_ill_flag", 32'(illegal_op_o), 1);
      check("flt_ill_drop", 32'(drop_cnt_o), 1);
      check("flt_ill_cnt", 32'(count_o), 0);
      check("flt_ill_ovf", 32'(overflow_o), 0);
      cyc(1'b1, 10'd2, 3'd7, 10'd0, 32'h3, 1'b0);
      check("flt_ill_other", 32'(drop_cnt_o), 1);

      // Fill and overflow
      do_reset();
      for (int i = 0; i < 5; i++) push(32'(i));
      check("ovf_count", 32'(count_o), 4);
      check("ovf_flag", 32'(overflow_o), 1);
      check("ovf_drop", 32'(drop_cnt_o), 1);
      check("ovf_ill", 32'(illegal_op_o), 0);
      for (int i = 0; i < 4; i++) begin
         check("ovf_pop_data", cmd_data_o, 32'(i));
         pop();
      end
      check("ovf_empty", 32'(count_o), 0);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) push(32'(i));
      cyc(1'b1, 10'd1, 3'd3, 10'd9, 32'd9, 1'b1);
      check("fpp_count", 32'(count_o), 4);
      check("fpp_ovf", 32'(overflow_o), 0);
      check("fpp_drop", 32'(drop_cnt_o), 0);
      for (int i = 0; i < 4; i++) begin
         check("fpp_pop_data", cmd_data_o,
               (i == 3) ? 32'd9 : 32'(i + 1));
         pop();
      end
      check("fpp_empty", 32'(count_o), 0);

      // Streaming across pointer wrap
      do_reset();
      push(32'd100);
      for (int i = 1; i < 20; i++) begin
         check("str_count", 32'(count_o), 1);
         check("str_data", cmd_data_o, 32'(100 + i - 1));
         cyc(1'b1, 10'd1, 3'd2, 10'(i), 32'(100 + i), 1'b1);
      end
      check("str_last", cmd_data_o, 32'd119);
      check("str_last_addr", 32'(cmd_addr_o), 19);
      pop();
      check("str_empty", 32'(count_o), 0);
      check("str_ovf", 32'(overflow_o), 0);

      // Drop counter saturation
      do_reset();
      for (int i = 0; i < 4; i++) push(32'(i));
      for (int i = 0; i < 254; i++) push(32'hF0);
      check("sat_254", 32'(drop_cnt_o), 254);
      push(32'hF0);
      check("sat_255", 32'(drop_cnt_o), 255);
      for (int i = 0; i < 45; i++) push(32'hF0);
      check("sat_hold", 32'(drop_cnt_o), 255);
      check("sat_count", 32'(count_o), 4);
      check("sat_head", cmd_data_o, 0);

      // Reset mid-operation
      do_reset();
      for (int i = 0; i < 5; i++) push(32'(i));
      pop();
      check("mid_pre_count", 32'(count_o), 3);
      check("mid_pre_ovf", 32'(overflow_o), 1);
      reset = 1'b0;
      cyc(1'b1, 10'd1, 3'd6, 10'd0, 32'hAA, 1'b0);
      reset = 1'b1;
      check("mid_count", 32'(count_o), 0);
      check("mid_valid", 32'(cmd_valid_o), 0);
      check("mid_op", 32'(cmd_op_o), 0);
      check("mid_ovf", 32'(overflow_o), 0);
      check("mid_ill", 32'(illegal_op_o), 0);
      check("mid_drop", 32'(drop_cnt_o), 0);
      cyc(1'b1, 10'd1, 3'd3, 10'd2, 32'h55, 1'b0);
      check("mid_push_valid", 32'(cmd_valid_o), 1);
      check("mid_push_op", 32'(cmd_op_o), 3);
      check("mid_push_data", cmd_data_o, 32'h55);
      check("mid_push_count", 32'(count_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
